// File: rtl/maj_net_pkg.sv
// Shared types and select-decode constants for the majority-gate network evaluator.
package maj_net_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_HOLD
    } state_t;

    localparam int SEL_CONST0  = 0;
    localparam int SEL_IN_BASE = 1;

    // Wide enough for the largest legal select space (1 + 10 inputs + 32 gates).
    localparam int SEL_MAX_W = 6;

    typedef struct packed {
        logic                 cmp;
        logic [SEL_MAX_W-1:0] sel;
    } operand_t;

endpackage

// File: rtl/maj_net_gate.sv
// One majority-of-three gate: decodes three {complement, select} operands
// against the primary inputs and the results of lower-index gates.
module maj_net_gate
    import maj_net_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int NUM_GATES = 8,
    parameter int SEL_W     = 4,
    parameter int GI_W      = 3
) (
    input  logic [3*(SEL_W+1)-1:0] ops,
    input  logic [NUM_IN-1:0]      x,
    input  logic [NUM_GATES-1:0]   gres,
    input  logic [GI_W-1:0]        gate_idx,
    output logic                   maj
);

    localparam int OP_W = SEL_W + 1;

    logic [2:0] v;

    always_comb begin
        operand_t op;
        logic     bit_v;
        v = '0;
        for (int o = 0; o < 3; o++) begin
            op.cmp = ops[o*OP_W + SEL_W];
            op.sel = SEL_MAX_W'(ops[o*OP_W +: SEL_W]);
            bit_v  = 1'b0;
            if (int'(op.sel) != SEL_CONST0) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (int'(op.sel) == SEL_IN_BASE + i) bit_v = x[i];
                end
                // Only strictly lower-index gates are visible; self/forward refs read 0.
                for (int g = 0; g < NUM_GATES; g++) begin
                    if (int'(op.sel) == SEL_IN_BASE + NUM_IN + g && g < int'(gate_idx))
                        bit_v = gres[g];
                end
            end
            v[o] = bit_v ^ op.cmp;
        end
        maj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    end

endmodule

// File: rtl/maj_net_eval.sv
// Programmable majority-gate network: evaluates one vector or sweeps the full
// truth table, one gate per cycle.
//   state | meaning
//   IDLE  | accepts config writes and evaluation requests
//   EVAL  | evaluating gate gcnt_q of vector (vec_q or latched x)
//   HOLD  | result presented, waiting for out_ready
module maj_net_eval
    import maj_net_pkg::*;
#(
    parameter  int NUM_IN    = 7,
    parameter  int NUM_GATES = 8,
    localparam int SEL_W     = $clog2(1 + NUM_IN + NUM_GATES),
    localparam int OP_W      = SEL_W + 1,
    localparam int TT_W      = 2**NUM_IN,
    localparam int AW        = $clog2(NUM_GATES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [3*OP_W-1:0] cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [NUM_IN-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic [TT_W-1:0]   out_tt,
    output logic              out_mode
);

    localparam int GI_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
    localparam logic [GI_W-1:0]   GATE_LAST = GI_W'(NUM_GATES - 1);
    localparam logic [NUM_IN-1:0] VEC_LAST  = '1;

    state_t              state_q, state_d;
    logic [GI_W-1:0]     gcnt_q, gcnt_d;
    logic [NUM_IN-1:0]   vec_q, vec_d;
    logic [NUM_IN-1:0]   x_q, x_d;
    logic                mode_q, mode_d;
    logic [NUM_GATES-1:0] gres_q, gres_d;
    logic [3*OP_W-1:0]   slot_q [NUM_GATES];
    logic [3*OP_W-1:0]   slot_d [NUM_GATES];
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic                out_cmp_q, out_cmp_d;
    logic                out_bit_q, out_bit_d;
    logic [TT_W-1:0]     out_tt_q, out_tt_d;
    logic                out_mode_q, out_mode_d;

    logic [3*OP_W-1:0]   cur_ops;
    logic [NUM_IN-1:0]   x_eval;
    logic                gate_bit;
    logic                obit;

    assign x_eval = mode_q ? vec_q : x_q;

    always_comb begin
        cur_ops = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            if (gcnt_q == GI_W'(g)) cur_ops = slot_q[g];
        end
    end

    maj_net_gate #(
        .NUM_IN    (NUM_IN),
        .NUM_GATES (NUM_GATES),
        .SEL_W     (SEL_W),
        .GI_W      (GI_W)
    ) u_gate (
        .ops      (cur_ops),
        .x        (x_eval),
        .gres     (gres_q),
        .gate_idx (gcnt_q),
        .maj      (gate_bit)
    );

    // Output bit sees the gate being written this cycle, so the last gate needs no extra pass.
    always_comb begin
        gres_d = gres_q;
        obit   = 1'b0;
        if (state_q == ST_EVAL) begin
            for (int g = 0; g < NUM_GATES; g++) begin
                if (gcnt_q == GI_W'(g)) gres_d[g] = gate_bit;
            end
        end
        for (int g = 0; g < NUM_GATES; g++) begin
            if (out_sel_q == SEL_W'(g)) obit = gres_d[g];
        end
        obit = obit ^ out_cmp_q;
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign in_ready  = (state_q == ST_IDLE) && !cfg_valid;
    assign out_valid = (state_q == ST_HOLD);
    assign out_bit   = out_bit_q;
    assign out_tt    = out_tt_q;
    assign out_mode  = out_mode_q;

    always_comb begin
        state_d    = state_q;
        gcnt_d     = gcnt_q;
        vec_d      = vec_q;
        x_d        = x_q;
        mode_d     = mode_q;
        slot_d     = slot_q;
        out_sel_d  = out_sel_q;
        out_cmp_d  = out_cmp_q;
        out_bit_d  = out_bit_q;
        out_tt_d   = out_tt_q;
        out_mode_d = out_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    for (int g = 0; g < NUM_GATES; g++) begin
                        if (int'(cfg_addr) == g) slot_d[g] = cfg_data;
                    end
                    if (int'(cfg_addr) == NUM_GATES) begin
                        out_sel_d = cfg_data[SEL_W-1:0];
                        out_cmp_d = cfg_data[SEL_W];
                    end
                end else if (in_valid) begin
                    state_d = ST_EVAL;
                    x_d     = in_x;
                    mode_d  = in_mode;
                    vec_d   = '0;
                    gcnt_d  = '0;
                end
            end
            ST_EVAL: begin
                if (gcnt_q == GATE_LAST) begin
                    gcnt_d = '0;
                    if (!mode_q) begin
                        out_bit_d  = obit;
                        out_mode_d = 1'b0;
                        state_d    = ST_HOLD;
                    end else begin
                        out_tt_d[vec_q] = obit;
                        if (vec_q == VEC_LAST) begin
                            out_bit_d  = obit;
                            out_mode_d = 1'b1;
                            state_d    = ST_HOLD;
                        end else begin
                            vec_d = vec_q + NUM_IN'(1);
                        end
                    end
                end else begin
                    gcnt_d = gcnt_q + GI_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gcnt_q     <= '0;
            vec_q      <= '0;
            x_q        <= '0;
            mode_q     <= 1'b0;
            gres_q     <= '0;
            for (int g = 0; g < NUM_GATES; g++) slot_q[g] <= '0;
            out_sel_q  <= '0;
            out_cmp_q  <= 1'b0;
            out_bit_q  <= 1'b0;
            out_tt_q   <= '0;
            out_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            vec_q      <= vec_d;
            x_q        <= x_d;
            mode_q     <= mode_d;
            gres_q     <= gres_d;
            slot_q     <= slot_d;
            out_sel_q  <= out_sel_d;
            out_cmp_q  <= out_cmp_d;
            out_bit_q  <= out_bit_d;
            out_tt_q   <= out_tt_d;
            out_mode_q <= out_mode_d;
        end
    end

endmodule

// File: tb/tb_maj_net_eval.sv
// Bench for maj_net_eval: directed programs and sweeps checked against a
// gate-network model plus hand-computed truth tables.
module tb_maj_net_eval;

    localparam int NI = 7;
    localparam int NG = 8;
    localparam int TT = 128;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [3:0]     cfg_addr = '0;
    logic [14:0]    cfg_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_mode = 1'b0;
    logic [NI-1:0]  in_x = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_bit;
    logic [TT-1:0]  out_tt;
    logic           out_mode;

    maj_net_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_tt    (out_tt),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Network model: program as plain select codes, evaluated gate by gate.
    int            psel [NG][3];
    logic          pcmp [NG][3];
    int            osel;
    logic          ocmp;
    logic [TT-1:0] last_tt;
    logic          exp_bit;
    logic [TT-1:0] exp_tt;
    logic          exp_mode;

    function automatic logic model_eval(input logic [NI-1:0] x);
        logic gv [NG];
        logic v;
        int   s, ones;
        for (int g = 0; g < NG; g++) begin
            ones = 0;
            for (int o = 0; o < 3; o++) begin
                s = psel[g][o];
                v = 1'b0;
                if (s >= 1 && s <= NI) v = x[s-1];
                else if (s >= NI + 1 && (s - NI - 1) < g) v = gv[s-NI-1];
                v = v ^ pcmp[g][o];
                if (v) ones++;
            end
            gv[g] = (ones >= 2);
        end
        return ((osel < NG) ? gv[osel] : 1'b0) ^ ocmp;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NG; g++)
            for (int o = 0; o < 3; o++) begin
                psel[g][o] = 0;
                pcmp[g][o] = 1'b0;
            end
        osel    = 0;
        ocmp    = 1'b0;
        last_tt = '0;
    endtask

    task automatic model_cfg(input int addr, input logic [14:0] data);
        if (addr < NG) begin
            for (int o = 0; o < 3; o++) begin
                psel[addr][o] = int'(data[o*5 +: 4]);
                pcmp[addr][o] = data[o*5+4];
            end
        end else if (addr == NG) begin
            osel = int'(data[3:0]);
            ocmp = data[4];
        end
    endtask

    function automatic logic [14:0] pk(input int a, input int b, input int c);
        return {5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic cfg_write(input int addr, input logic [14:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_data  = data;
        #1;
        chk("cfg_ready_idle", cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        model_cfg(addr, data);
    endtask

    task automatic start_eval(input logic mode, input logic [NI-1:0] x, input int exp_lat, input string name);
        int lat;
        logic [TT-1:0] tt;
        if (mode) begin
            for (int k = 0; k < TT; k++) tt[k] = model_eval(NI'(k));
            exp_tt   = tt;
            exp_bit  = tt[TT-1];
            exp_mode = 1'b1;
            last_tt  = tt;
        end else begin
            exp_bit  = model_eval(x);
            exp_tt   = last_tt;
            exp_mode = 1'b0;
        end
        in_valid = 1'b1;
        in_mode  = mode;
        in_x     = x;
        #1;
        chk({name, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic release_out(input int hold);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 1'b0);
        chk("in_ready_after", in_ready, 1'b1);
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_out_valid"}, out_valid, 1'b0);
        chk({name, "_out_bit"}, out_bit, 1'b0);
        chk({name, "_out_tt"}, out_tt, '0);
        chk({name, "_out_mode"}, out_mode, 1'b0);
        chk({name, "_cfg_ready"}, cfg_ready, 1'b1);
        chk({name, "_in_ready"}, in_ready, 1'b1);
    endtask

    // Every cycle a result is presented, it must match the model and block new work.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("cmp_out_bit", out_bit, exp_bit);
            chk("cmp_out_tt", out_tt, exp_tt);
            chk("cmp_out_mode", out_mode, exp_mode);
            chk("cmp_cfg_ready", cfg_ready, 1'b0);
            chk("cmp_in_ready", in_ready, 1'b0);
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;
        #1;
        reset_checks("post_rst");

        start_eval(1'b1, '0, 1025, "sweep0");
        chk("sweep0_tt_lit", out_tt, '0);
        chk("sweep0_bit_lit", out_bit, 1'b0);
        release_out(2);

        cfg_write(0, pk(1, 2, 7));
        cfg_write(1, pk(1, 3, 4));
        cfg_write(2, pk(2, 6, 9));
        cfg_write(3, pk(5, 8, 10));
        cfg_write(4, pk(1, 3, 11));
        cfg_write(5, pk(4, 11, 12));
        cfg_write(NG, 15'd5);
        start_eval(1'b1, '0, 1025, "sweep_prog");
        chk("sweep_prog_tt_lit", out_tt, 128'hfeeaeee8eeeae880fee8a888e888a880);
        chk("sweep_prog_bit_lit", out_bit, 1'b1);
        // Config attempts while a result is held must be refused.
        cfg_valid = 1'b1;
        cfg_addr  = 4'd5;
        cfg_data  = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("hold_cfg_refused", cfg_ready, 1'b0);
        end
        cfg_valid = 1'b0;
        release_out(0);

        start_eval(1'b0, 7'h7F, 9, "single_ones");
        chk("single_ones_bit_lit", out_bit, 1'b1);
        chk("single_ones_mode_lit", out_mode, 1'b0);
        release_out(1);
        start_eval(1'b0, 7'h00, 9, "single_zeros");
        chk("single_zeros_bit_lit", out_bit, 1'b0);
        chk("single_tt_retained_lit", out_tt, 128'hfeeaeee8eeeae880fee8a888e888a880);
        release_out(1);

        // Simultaneous cfg and eval request: cfg wins, eval waits a cycle.
        cfg_valid = 1'b1;
        cfg_addr  = 4'(NG);
        cfg_data  = 15'h14;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_x      = 7'h7F;
        #1;
        chk("prio_in_ready", in_ready, 1'b0);
        chk("prio_cfg_ready", cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        model_cfg(NG, 15'h14);
        start_eval(1'b0, 7'h7F, 9, "prio_eval");
        chk("prio_eval_bit_lit", out_bit, 1'b0);
        release_out(1);

        cfg_write(6, pk(14, 1, 16));
        cfg_write(NG, 15'd6);
        start_eval(1'b1, '0, 1025, "selfref");
        chk("selfref_tt_lit", out_tt, {32{4'hA}});
        release_out(1);

        in_valid = 1'b1;
        in_mode  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        reset_checks("mid_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        reset_checks("mid_post_rst");
        start_eval(1'b1, '0, 1025, "sweep_after_rst");
        chk("sweep_after_rst_tt_lit", out_tt, '0);
        release_out(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maj_net_eval.md
MAJ_NET_EVAL -- requirements
Module: maj_net_eval

Interface
REQ-001 Parameter NUM_IN, default 7: number of primary inputs, legal range 2..10.
REQ-002 Parameter NUM_GATES, default 8: number of majority-of-three gate slots, legal range 1..32.
REQ-003 Derived constants: SEL_W = clog2(1+NUM_IN+NUM_GATES); OP_W = SEL_W+1; TT_W = 2**NUM_IN.
REQ-004 Port clk, input, 1: the single clock, rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port cfg_valid, input, 1: configuration write request.
REQ-007 Port cfg_ready, output, 1: configuration write accepted.
REQ-008 Port cfg_addr, input, clog2(NUM_GATES+1): gate slot 0..NUM_GATES-1; address NUM_GATES selects the output register.
REQ-009 Port cfg_data, input, 3*OP_W: three operands, each {complement, select}, with operand a in the LSBs.
REQ-010 Port in_valid, input, 1: evaluation request.
REQ-011 Port in_ready, output, 1: evaluation request accepted.
REQ-012 Port in_mode, input, 1: 0 = single vector, 1 = full truth-table sweep.
REQ-013 Port in_x, input, NUM_IN: input vector, used in single mode only.
REQ-014 Port out_valid, output, 1: result available.
REQ-015 Port out_ready, input, 1: result consumed.
REQ-016 Port out_bit, output, 1: single-mode result.
REQ-017 Port out_tt, output, TT_W: sweep result; bit k holds f(k).
REQ-018 Port out_mode, output, 1: mode of the presented result.

Function
REQ-019 Select encoding SHALL be: 0 = constant 0; 1..NUM_IN = x[s-1]; NUM_IN+1+g = result of gate g; other codes read 0.
REQ-020 A gate SHALL compute maj(a^ca, b^cb, c^cc).
REQ-021 A gate that references its own or a higher-index gate SHALL read 0 for that operand.
REQ-022 The state machine SHALL have states IDLE, EVAL, HOLD.
REQ-023 cfg_ready SHALL be 1 only in IDLE; an accepted write updates the slot on the same edge.
REQ-024 The output register SHALL hold a gate index plus an output complement bit, taken from the operand-a field of cfg_data.
REQ-025 in_ready SHALL be 1 only in IDLE and only when cfg_valid is 0; a simultaneous cfg write takes priority.
REQ-026 Accepting an evaluation request SHALL move the block IDLE->EVAL, latching in_x and in_mode and clearing the vector counter.
REQ-027 In EVAL, one gate SHALL be evaluated per cycle in index order 0..NUM_GATES-1, with results stored in a gate-result register.
REQ-028 Single-mode latency from acceptance to out_valid SHALL be exactly NUM_GATES+1 cycles.
REQ-029 In sweep mode, vector k = 0..TT_W-1 SHALL be evaluated in turn and the output bit written to out_tt[k].
REQ-030 Sweep-mode latency SHALL be TT_W*NUM_GATES+1 cycles, with the vector counter stopping at TT_W-1 and not wrapping.
REQ-031 After the last gate of the last vector, the block SHALL enter HOLD with out_valid=1.
REQ-032 out_bit, out_tt and out_mode SHALL be stable while out_valid=1.
REQ-033 HOLD->IDLE SHALL occur on out_valid && out_ready; out_valid SHALL drop the following cycle.
REQ-034 In single mode, out_tt SHALL retain its previous value; in sweep mode, out_bit SHALL equal out_tt[TT_W-1].

Reset
REQ-035 Reset assertion SHALL at any time, including mid-EVAL, force IDLE and abandon any in-flight evaluation.
REQ-036 During and after reset: out_valid=0, out_bit=0, out_tt=0, out_mode=0, cfg_ready=1, in_ready=1.
REQ-037 Reset SHALL set every gate slot to all-zero (constant-0 output) and the output register to gate 0, uncomplemented.

Structure
REQ-038 Package maj_net_pkg SHALL hold the state enum, the select-decode constants for const0 and input base, and an operand struct {cmp, sel}.
REQ-039 One sub-module maj_net_gate SHALL decode three operands against the input and gate-result vectors and produce the majority bit.

Verification
REQ-040 Reset, then an immediate sweep request -> out_tt = 0 after 1025 cycles at default parameters.
REQ-041 Program g0=maj(x0,x1,x6), g1=maj(x0,x2,x3), g2=maj(x1,x5,g1), g3=maj(x4,g0,g2), g4=maj(x0,x2,g3), g5=maj(x3,g3,g4), output=g5, then sweep -> out_tt = 128'hfeeaeee8eeeae880fee8a888e888a880.
REQ-042 Same program, single mode, in_x=7'h7F -> out_bit=1 after 9 cycles; in_x=7'h00 -> out_bit=0.
REQ-043 Hold out_ready=0 for 20 cycles -> out_valid, out_bit and out_tt stay constant, and cfg_valid is not accepted (cfg_ready=0).
REQ-044 Assert rst_n low for one cycle mid-sweep -> IDLE, outputs cleared, program reset to all-zero, next sweep gives out_tt = 0.
REQ-045 Drive cfg_valid and in_valid together in IDLE -> the cfg write is accepted, in_ready=0 that cycle, and evaluation starts only after cfg_valid drops.
